// File: rtl/fpu_f2i_iter.sv
// Iterative single-precision float to 32-bit integer converter (FCVT.W.S / FCVT.WU.S).
// Optional macro FPU_F2I_BARREL_EN replaces the bit-serial shift with a one-cycle barrel shift.
module fpu_f2i_iter #(
  parameter int PARAM_Fp_size       = 32,
  parameter int PARAM_Mantissa_size = 23,
  parameter int PARAM_Exponent_size = 8,
  parameter int PARAM_Int_size      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PARAM_Fp_size-1:0]  A,
  input  logic [2:0]                rm,
  input  logic [2:0]                frm,
  input  logic                      is_unsigned,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PARAM_Int_size-1:0] Out,
  output logic                      flag_nv,
  output logic                      flag_nx
);

  localparam int MS = PARAM_Mantissa_size;
  localparam int ES = PARAM_Exponent_size;
  localparam int IS = PARAM_Int_size;
  localparam int WW = IS + MS;
  localparam int NW = $clog2(IS) + 1;

  localparam logic [ES-1:0] BIAS   = {1'b0, {(ES-1){1'b1}}};
  localparam logic [ES-1:0] E_HALF = BIAS - ES'(1);
  localparam logic [ES-1:0] E_OVF  = BIAS + ES'(IS);
  localparam logic [IS:0]   MAX_POS = {2'b00, {(IS-1){1'b1}}};
  localparam logic [IS:0]   MAX_NEG = {2'b01, {(IS-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, ROUND, DONE} state_t;

  state_t state, state_nxt;

  logic [PARAM_Fp_size-1:0] a_r;
  logic [2:0]               rm_r;
  logic                     uns_r;
  logic [WW-1:0]            w;
  logic                     sticky;
  logic [NW-1:0]            cnt;
  logic                     shr;
  logic [IS-1:0]            out_r;
  logic                     nv_r;
  logic                     nx_r;

  // Operand decode, valid while in UNPACK
  logic          sgn;
  logic [ES-1:0] exp_f;
  logic [MS-1:0] man;
  logic          is_nan, is_big, is_zero, is_tiny, is_half;
  logic [WW-1:0] w_load;
  logic [IS-1:0] sat_pos, sat_neg;

  assign sgn     = a_r[PARAM_Fp_size-1];
  assign exp_f   = a_r[MS+ES-1:MS];
  assign man     = a_r[MS-1:0];
  assign is_nan  = (&exp_f) & (|man);
  assign is_big  = (&exp_f) | (exp_f >= E_OVF);
  assign is_zero = (exp_f == '0) & (man == '0);
  assign is_tiny = (exp_f < E_HALF);
  assign is_half = (exp_f == E_HALF);
  assign w_load  = {{(IS-1){1'b0}}, 1'b1, man};
  assign sat_pos = uns_r ? '1 : {1'b0, {(IS-1){1'b1}}};
  assign sat_neg = uns_r ? '0 : {1'b1, {(IS-1){1'b0}}};

  // Rounding and range check, valid while in ROUND
  logic          rnd_g, rnd_st, rnd_lsb, rnd_inc;
  logic [IS:0]   mag;
  logic [IS-1:0] res;
  logic          res_nv, res_nx;

  always_comb begin
    rnd_g   = w[MS-1];
    rnd_st  = (|w[MS-2:0]) | sticky;
    rnd_lsb = w[MS];
    case (rm_r)
      3'b001:  rnd_inc = 1'b0;
      3'b010:  rnd_inc = (rnd_g | rnd_st) & sgn;
      3'b011:  rnd_inc = (rnd_g | rnd_st) & ~sgn;
      3'b100:  rnd_inc = rnd_g;
      default: rnd_inc = rnd_g & (rnd_st | rnd_lsb);
    endcase
    mag    = {1'b0, w[WW-1:MS]} + {{IS{1'b0}}, rnd_inc};
    res    = '0;
    res_nv = 1'b0;
    if (uns_r) begin
      if (sgn && (mag != '0)) begin
        res_nv = 1'b1;
        res    = '0;
      end else if (!sgn && mag[IS]) begin
        res_nv = 1'b1;
        res    = '1;
      end else begin
        res    = mag[IS-1:0];
      end
    end else begin
      if (!sgn && (mag > MAX_POS)) begin
        res_nv = 1'b1;
        res    = sat_pos;
      end else if (sgn && (mag > MAX_NEG)) begin
        res_nv = 1'b1;
        res    = sat_neg;
      end else begin
        res    = sgn ? -mag[IS-1:0] : mag[IS-1:0];
      end
    end
    res_nx = (rnd_g | rnd_st) & ~res_nv;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (in_valid) state_nxt = UNPACK;
      UNPACK: begin
        if (is_nan || is_big)        state_nxt = DONE;
        else if (is_zero || is_tiny) state_nxt = ROUND;
`ifdef FPU_F2I_BARREL_EN
        else                         state_nxt = ROUND;
`else
        else if (is_half)            state_nxt = SHIFT;
        else if (exp_f == BIAS)      state_nxt = ROUND;
        else                         state_nxt = SHIFT;
`endif
      end
      SHIFT:  if (cnt == NW'(1)) state_nxt = ROUND;
      ROUND:  state_nxt = DONE;
      DONE:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r    <= '0;
      rm_r   <= '0;
      uns_r  <= 1'b0;
      w      <= '0;
      sticky <= 1'b0;
      cnt    <= '0;
      shr    <= 1'b0;
      out_r  <= '0;
      nv_r   <= 1'b0;
      nx_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= A;
          rm_r  <= (rm == 3'b111) ? frm : rm;
          uns_r <= is_unsigned;
        end
        UNPACK: begin
          w      <= w_load;
          sticky <= 1'b0;
          shr    <= 1'b0;
          if (is_nan) begin
            out_r <= sat_pos;
            nv_r  <= 1'b1;
            nx_r  <= 1'b0;
          end else if (is_big) begin
            out_r <= sgn ? sat_neg : sat_pos;
            nv_r  <= 1'b1;
            nx_r  <= 1'b0;
          end else if (is_zero) begin
            w <= '0;
          end else if (is_tiny) begin
            w      <= '0;
            sticky <= 1'b1;
          end else if (is_half) begin
`ifdef FPU_F2I_BARREL_EN
            w      <= w_load >> 1;
            sticky <= w_load[0];
`else
            shr <= 1'b1;
            cnt <= NW'(1);
`endif
          end else begin
`ifdef FPU_F2I_BARREL_EN
            w <= w_load << (exp_f - BIAS);
`else
            cnt <= NW'(exp_f - BIAS);
`endif
          end
        end
        SHIFT: begin
          cnt <= cnt - NW'(1);
          if (shr) begin
            w      <= w >> 1;
            sticky <= sticky | w[0];
          end else begin
            w <= w << 1;
          end
        end
        ROUND: begin
          out_r <= res;
          nv_r  <= res_nv;
          nx_r  <= res_nx;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign Out       = out_r;
  assign flag_nv   = nv_r;
  assign flag_nx   = nx_r;

endmodule
